vx_shift_register_elastic: RTL

VX_SHIFT_REGISTER_ELASTIC -- requirements
Module: VX_shift_register_elastic

---
 rtl/vx_shift_register_elastic.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/vx_shift_register_elastic.sv
// ============================================================================
// vx_shift_register_elastic
//
// Elastic shift register: a DEPTH-stage pipeline with a valid/ready handshake
// on both ends. Every stage carries its own valid bit. A stage advances
// whenever it is empty or the stage after it is advancing, so bubbles collapse
// and an entry reaches the output as soon as the stages ahead of it allow.
// With the downstream always ready, the latency is exactly DEPTH cycles and
// the throughput is one entry per cycle.
//
// Parameters
//   DATAW   payload width in bits (>= 1)
//   DEPTH   number of stages (>= 2)
//   RESETW  number of payload MSBs cleared by reset (0..DATAW)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   flush        synchronous discard of every entry; blocks acceptance
//   valid_in     upstream entry valid
//   data_in      upstream payload
//   ready_in     stage 0 can accept this cycle
//   valid_out    last stage holds an entry
//   data_out     payload of the last stage
//   ready_out    downstream accepts this cycle
//   count        number of valid stages (registered)
//   perf_stalls  cycles where valid_out=1 and ready_out=0 (saturating)
//
// Build option
//   VX_SHIFT_REGISTER_ELASTIC_STATS_EN  when defined, perf_stalls is a live
//   saturating stall counter that flush does not clear; when undefined,
//   perf_stalls is tied to zero and no counter exists.
// ============================================================================
module vx_shift_register_elastic #(
    parameter int DATAW  = 8,
    parameter int DEPTH  = 4,
    parameter int RESETW = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       valid_in,
    input  logic [DATAW-1:0]           data_in,
    output logic                       ready_in,
    output logic                       valid_out,
    output logic [DATAW-1:0]           data_out,
    input  logic                       ready_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [31:0]                perf_stalls
);

    localparam int CNTW = $clog2(DEPTH+1);

    // Per-stage state and the values offered to each stage.
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_in;
    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] load;
    logic [DATAW-1:0] dat    [DEPTH];
    logic [DATAW-1:0] dat_in [DEPTH];

    logic accept;
    logic retire;

    // Stage i receives the valid bit of stage i-1; stage 0 receives valid_in.
    assign vld_in = {vld[DEPTH-2:0], valid_in};

    // Ready ripples backwards from the output. Computed in one block, walking
    // from the last stage down, so the chain resolves within a single pass.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = ready_out;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !vld[i] || rdy[i+1];
        end
    end

    assign ready_in  = rdy[0] && !flush;
    assign valid_out = vld[DEPTH-1];
    assign data_out  = dat[DEPTH-1];

    assign accept = valid_in && ready_in;
    assign retire = valid_out && ready_out;

    // Payload only moves when a real entry moves into the stage; an advancing
    // bubble leaves the old payload in place.
    assign load = rdy[DEPTH-1:0] & vld_in & {DEPTH{~flush}};

    // ------------------------------------------------------------------------
    // Valid bits: advance where ready, all cleared on flush.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
        end else if (flush) begin
            vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    vld[i] <= vld_in[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Payload stages. The top RESETW bits sit in an async-reset register; the
    // remaining bits are plain flops with no reset. The split is done per
    // stage so that RESETW=0 and RESETW=DATAW never need a zero-width field.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_src_in
            assign dat_in[i] = data_in;
        end else begin : g_src_prev
            assign dat_in[i] = dat[i-1];
        end

        if (RESETW == 0) begin : g_no_rst
            logic [DATAW-1:0] lo;
            always_ff @(posedge clk) begin
                if (load[i]) begin
                    lo <= dat_in[i];
                end
            end
            assign dat[i] = lo;
        end else if (RESETW == DATAW) begin : g_all_rst
            logic [DATAW-1:0] hi;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    hi <= '0;
                end else if (load[i]) begin
                    hi <= dat_in[i];
                end
            end
            assign dat[i] = hi;
        end else begin : g_part_rst
            logic [RESETW-1:0]       hi;
            logic [DATAW-RESETW-1:0] lo;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    hi <= '0;
                end else if (load[i]) begin
                    hi <= dat_in[i][DATAW-1:DATAW-RESETW];
                end
            end
            always_ff @(posedge clk) begin
                if (load[i]) begin
                    lo <= dat_in[i][DATAW-RESETW-1:0];
                end
            end
            assign dat[i] = {hi, lo};
        end
    end

    // ------------------------------------------------------------------------
    // Occupancy count. Accept and retire can both happen in one cycle; flush
    // wins because it empties every stage at the same edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CNTW'(accept) - CNTW'(retire);
        end
    end

    // ------------------------------------------------------------------------
    // Output stall statistics.
    // ------------------------------------------------------------------------
`ifdef VX_SHIFT_REGISTER_ELASTIC_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

    logic [31:0] stall_cnt;

    // Only reset clears the counter; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (valid_out && !ready_out) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign perf_stalls = stall_cnt;
`else
    assign perf_stalls = 32'd0;
`endif

endmodule
